// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and control FSM states for the sequential ALU.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_MOD = 5'b00100;
    localparam logic [4:0] OP_LSL = 5'b00101;
    localparam logic [4:0] OP_LSR = 5'b00110;
    localparam logic [4:0] OP_ASR = 5'b00111;
    localparam logic [4:0] OP_XOR = 5'b01000;
    localparam logic [4:0] OP_OR  = 5'b01001;
    localparam logic [4:0] OP_AND = 5'b01010;
    localparam logic [4:0] OP_NOT = 5'b01011;
    localparam logic [4:0] OP_CMP = 5'b01100;
    localparam logic [4:0] OP_INC = 5'b01101;
    localparam logic [4:0] OP_DEC = 5'b01110;
    localparam logic [4:0] OP_MAC = 5'b01111;
    localparam logic [4:0] OP_CLR = 5'b10000;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {StIdle, StIter, StFix} alu_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative signed multiply / restoring divide on operand magnitudes, one step per cycle,
// with sign fixup applied combinationally on the outputs.
module alu_muldiv_seq #(
    parameter int unsigned W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic           is_div,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           last,
    output logic [2*W-1:0] product,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder
);
    localparam int unsigned CW = $clog2(W);

    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] work_q, work_d, shifted;
    logic [W-1:0]   m_q, a_mag, b_mag;
    logic           div_q, sa_q, sb_q;
    logic [W:0]     add_sum, sub_trial;

    always_comb begin
        a_mag     = a[W-1] ? (~a + W'(1)) : a;
        b_mag     = b[W-1] ? (~b + W'(1)) : b;
        shifted   = {work_q[2*W-2:0], 1'b0};
        add_sum   = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, m_q} : '0);
        sub_trial = {1'b0, shifted[2*W-1:W]} - {1'b0, m_q};
        // Divide: high half is the partial remainder, low half collects quotient bits.
        if (div_q) begin
            work_d = sub_trial[W] ? shifted : {sub_trial[W-1:0], shifted[W-1:1], 1'b1};
        end else begin
            work_d = {add_sum, work_q[W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            work_q <= '0;
            m_q    <= '0;
            div_q  <= 1'b0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
        end else if (load) begin
            cnt_q  <= CW'(W - 1);
            work_q <= {{W{1'b0}}, is_div ? a_mag : b_mag};
            m_q    <= is_div ? b_mag : a_mag;
            div_q  <= is_div;
            sa_q   <= a[W-1];
            sb_q   <= b[W-1];
        end else if (step) begin
            work_q <= work_d;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign last      = (cnt_q == '0);
    assign product   = (sa_q ^ sb_q) ? (~work_q + (2*W)'(1)) : work_q;
    assign quotient  = (sa_q ^ sb_q) ? (~work_q[W-1:0] + W'(1)) : work_q[W-1:0];
    assign remainder = sa_q ? (~work_q[2*W-1:W] + W'(1)) : work_q[2*W-1:W];

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with persistent accumulator: single-cycle ops finish in one clock,
// MUL/DIV/MOD/MAC run on the iterative unit and take W+2 cycles.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [4:0]   alu_op,
    input  logic [W-1:0] operandA,
    input  logic [W-1:0] operandB,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] resultAccumulator,
    output logic [3:0]   flags
);
    localparam int unsigned SW = $clog2(W);

    alu_state_e     state_q, state_d;
    logic [4:0]     op_q;
    logic           div_ovf_q, done_q, done_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [3:0]     flags_q, flags_d;
    logic           is_multi, md_load, md_step, md_last;
    logic [2*W-1:0] md_product;
    logic [W-1:0]   md_quotient, md_remainder;

    logic [W-1:0]   addend, sc_res, sc_val, fix_res;
    logic [W:0]     add_full, sub_full, lsl_full, lsr_full, asr_full;
    logic [SW-1:0]  shamt;
    logic           sc_c, sc_v, sc_write, fix_v;
    logic [3:0]     sc_flags, fix_flags;
    logic [2*W:0]   mac_full;

    // Zero divisors never reach the iterative unit; they complete immediately.
    assign is_multi = (alu_op == OP_MUL) || (alu_op == OP_MAC) ||
                      (((alu_op == OP_DIV) || (alu_op == OP_MOD)) && (operandB != '0));

    alu_muldiv_seq #(.W(W)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .load      (md_load),
        .step      (md_step),
        .is_div    ((alu_op == OP_DIV) || (alu_op == OP_MOD)),
        .a         (operandA),
        .b         (operandB),
        .last      (md_last),
        .product   (md_product),
        .quotient  (md_quotient),
        .remainder (md_remainder)
    );

    always_comb begin
        addend   = ((alu_op == OP_INC) || (alu_op == OP_DEC)) ? W'(1) : operandB;
        add_full = {1'b0, operandA} + {1'b0, addend};
        sub_full = {1'b0, operandA} - {1'b0, addend};
        shamt    = operandB[SW-1:0];
        lsl_full = {1'b0, operandA} << shamt;
        lsr_full = {operandA, 1'b0} >> shamt;
        asr_full = $signed({operandA, 1'b0}) >>> shamt;
        sc_res   = acc_q;
        sc_val   = acc_q;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_write = 1'b1;
        case (alu_op)
            OP_ADD, OP_INC: begin
                sc_res = add_full[W-1:0];
                sc_c   = add_full[W];
                sc_v   = (operandA[W-1] == addend[W-1]) && (add_full[W-1] != operandA[W-1]);
            end
            OP_SUB, OP_DEC, OP_CMP: begin
                sc_val = sub_full[W-1:0];
                if (alu_op != OP_CMP) sc_res = sub_full[W-1:0];
                sc_c   = sub_full[W];
                sc_v   = (operandA[W-1] != addend[W-1]) && (sub_full[W-1] != operandA[W-1]);
            end
            OP_DIV: begin sc_res = '1;       sc_v = 1'b1; end
            OP_MOD: begin sc_res = operandA; sc_v = 1'b1; end
            OP_LSL: begin sc_res = lsl_full[W-1:0]; sc_c = lsl_full[W]; end
            OP_LSR: begin sc_res = lsr_full[W:1];   sc_c = lsr_full[0]; end
            OP_ASR: begin sc_res = asr_full[W:1];   sc_c = asr_full[0]; end
            OP_XOR: sc_res = operandA ^ operandB;
            OP_OR:  sc_res = operandA | operandB;
            OP_AND: sc_res = operandA & operandB;
            OP_NOT: sc_res = ~operandA;
            OP_CLR: sc_res = '0;
            default: sc_write = 1'b0;
        endcase
        if (alu_op != OP_CMP) sc_val = sc_res;
        sc_flags         = '0;
        sc_flags[FLAG_N] = sc_val[W-1];
        sc_flags[FLAG_Z] = (sc_val == '0);
        sc_flags[FLAG_C] = sc_c;
        sc_flags[FLAG_V] = sc_v;
        if (alu_op == OP_CLR) sc_flags = '0;
    end

    always_comb begin
        mac_full = {{(W+1){acc_q[W-1]}}, acc_q} + {md_product[2*W-1], md_product};
        fix_res  = md_remainder;
        fix_v    = 1'b0;
        case (op_q)
            OP_MUL: begin
                fix_res = md_product[W-1:0];
                fix_v   = !((&md_product[2*W-1:W-1]) || (~|md_product[2*W-1:W-1]));
            end
            OP_MAC: begin
                fix_res = mac_full[W-1:0];
                fix_v   = !((&mac_full[2*W:W-1]) || (~|mac_full[2*W:W-1]));
            end
            OP_DIV: begin
                fix_res = md_quotient;
                fix_v   = div_ovf_q;
            end
            default: ;
        endcase
        fix_flags         = '0;
        fix_flags[FLAG_N] = fix_res[W-1];
        fix_flags[FLAG_Z] = (fix_res == '0);
        fix_flags[FLAG_V] = fix_v;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        md_load = 1'b0;
        md_step = 1'b0;
        case (state_q)
            StIdle: if (start && is_multi) begin
                state_d = StIter;
                md_load = 1'b1;
            end
            StIter: begin
                md_step = 1'b1;
                if (md_last) state_d = StFix;
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        if ((state_q == StIdle) && start && !is_multi) begin
            done_d = 1'b1;
            if (sc_write) begin
                acc_d   = sc_res;
                flags_d = sc_flags;
            end
        end else if (state_q == StFix) begin
            done_d  = 1'b1;
            acc_d   = fix_res;
            flags_d = fix_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            op_q      <= '0;
            div_ovf_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            if (md_load) begin
                op_q      <= alu_op;
                div_ovf_q <= (operandA == {1'b1, {(W-1){1'b0}}}) && (operandB == '1);
            end
        end
    end

    assign busy              = (state_q != StIdle);
    assign done              = done_q;
    assign resultAccumulator = acc_q;
    assign flags             = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal cases plus random traffic against an arithmetic model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [4:0]   alu_op = '0;
    logic [W-1:0] operandA = '0;
    logic [W-1:0] operandB = '0;
    logic         busy, done;
    logic [W-1:0] resultAccumulator;
    logic [3:0]   flags;

    int errors = 0;
    int checks = 0;

    // Model state: what the outputs must show after each edge.
    logic [15:0] m_res = '0, p_res = '0;
    logic [3:0]  m_flags = '0, p_flags = '0;
    bit          m_busy = 0, m_done = 0, cmp_en = 0;
    int          m_left = 0;

    alu_seq #(.W(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .alu_op            (alu_op),
        .operandA          (operandA),
        .operandB          (operandB),
        .busy              (busy),
        .done              (done),
        .resultAccumulator (resultAccumulator),
        .flags             (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit fits(input longint x);
        return (x >= -32768) && (x <= 32767);
    endfunction

    function automatic void model_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] acc, input logic [3:0] fl,
                                     output logic [15:0] r, output logic [3:0] f, output bit multi);
        longint sa, sb, sacc, ua, ub, ob, sob, t;
        logic [15:0] nz;
        bit c, v;
        int n;
        sa = longint'($signed(a)); sb = longint'($signed(b)); sacc = longint'($signed(acc));
        ua = longint'(a); ub = longint'(b);
        ob  = (op == OP_INC || op == OP_DEC) ? 1 : ub;
        sob = (op == OP_INC || op == OP_DEC) ? 1 : sb;
        n = int'(b[3:0]);
        c = 0; v = 0; multi = 0; r = acc;
        case (op)
            OP_ADD, OP_INC: begin t = ua + ob; r = t[15:0]; c = t[16]; v = !fits(sa + sob); end
            OP_SUB, OP_DEC, OP_CMP: begin
                t = ua - ob; c = (ua < ob); v = !fits(sa - sob);
                if (op != OP_CMP) r = t[15:0];
            end
            OP_MUL: begin t = sa * sb; r = t[15:0]; v = !fits(t); multi = 1; end
            OP_MAC: begin t = sacc + sa * sb; r = t[15:0]; v = !fits(t); multi = 1; end
            OP_DIV: begin
                if (sb == 0) begin r = 16'hFFFF; v = 1; end
                else begin
                    multi = 1;
                    if (sa == -32768 && sb == -1) begin r = 16'h8000; v = 1; end
                    else begin t = sa / sb; r = t[15:0]; end
                end
            end
            OP_MOD: begin
                if (sb == 0) begin r = a; v = 1; end
                else begin multi = 1; t = sa % sb; r = t[15:0]; end
            end
            OP_LSL: begin t = ua << n; r = t[15:0]; c = t[16]; end
            OP_LSR: begin t = ua >> n; r = t[15:0]; c = (n != 0) && (((ua >> (n - 1)) & 1) != 0); end
            OP_ASR: begin t = sa >>> n; r = t[15:0]; c = (n != 0) && (((ua >> (n - 1)) & 1) != 0); end
            OP_XOR: r = a ^ b;
            OP_OR:  r = a | b;
            OP_AND: r = a & b;
            OP_NOT: r = ~a;
            OP_CLR: r = '0;
            default: begin f = fl; return; end
        endcase
        nz = (op == OP_CMP) ? 16'(ua - ob) : r;
        f = {nz[15], nz == 16'h0, c, v};
        if (op == OP_CLR) f = 4'b0000;
    endfunction

    always @(posedge clk) begin
        logic [15:0] r;
        logic [3:0]  f;
        bit          mu;
        if (rst) begin
            m_res = '0; m_flags = '0; m_busy = 0; m_done = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_res = p_res; m_flags = p_flags; m_done = 1; m_busy = 0;
                end
            end else if (start) begin
                model_op(alu_op, operandA, operandB, m_res, m_flags, r, f, mu);
                if (mu) begin
                    p_res = r; p_flags = f; m_left = W + 1; m_busy = 1;
                end else begin
                    m_res = r; m_flags = f; m_done = 1;
                end
            end
        end
        cmp_en = 1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("result", 32'(resultAccumulator), 32'(m_res));
            check("flags", 32'(flags), 32'(m_flags));
        end
    end

    // Issue one op; optionally poke a stray start or a reset at the given cycle.
    task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int poke_at, input bit poke_rst, output int lat);
        @(posedge clk); #1;
        start = 1'b1; alu_op = op; operandA = a; operandB = b;
        @(posedge clk); #1;
        start = 1'b0; lat = 1;
        while (!done && lat < 40) begin
            if (lat == poke_at) begin
                if (poke_rst) rst = 1'b1;
                else begin start = 1'b1; alu_op = OP_ADD; operandA = 16'h0001; operandB = 16'h0001; end
            end
            @(posedge clk); #1;
            rst = 1'b0; start = 1'b0; lat++;
        end
    endtask

    function automatic logic [15:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'hFFFF;
            3: return 16'h8000;
            4: return 16'h7FFF;
            5: return 16'($urandom_range(0, 31));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_res", 32'(resultAccumulator), 0);
        check("rst_flags", 32'(flags), 0);

        run_op(OP_AND, 16'hFFE0, 16'h0005, 0, 0, lat);
        check("and_res", 32'(resultAccumulator), 32'h0000);
        check("and_flags", 32'(flags), 32'b0100);
        check("and_lat", lat, 1);

        run_op(OP_ADD, 16'h7FFF, 16'h0001, 0, 0, lat);
        check("add_res", 32'(resultAccumulator), 32'h8000);
        check("add_flags", 32'(flags), 32'b1001);

        run_op(OP_SUB, 16'h0000, 16'h0001, 0, 0, lat);
        check("sub_res", 32'(resultAccumulator), 32'hFFFF);
        check("sub_flags", 32'(flags), 32'b1010);

        run_op(OP_CMP, 16'h0005, 16'h0005, 0, 0, lat);
        check("cmp_res", 32'(resultAccumulator), 32'hFFFF);
        check("cmp_flags", 32'(flags), 32'b0100);

        run_op(OP_MUL, 16'hFED4, 16'h0007, 5, 0, lat);
        check("mul_res", 32'(resultAccumulator), 32'hF7CC);
        check("mul_flags", 32'(flags), 32'b1000);
        check("mul_lat", lat, 18);

        run_op(OP_MUL, 16'd300, 16'd300, 0, 0, lat);
        check("mul_ovf_res", 32'(resultAccumulator), 32'd24464);
        check("mul_ovf_flags", 32'(flags), 32'b0001);

        run_op(OP_DIV, 16'hFFF9, 16'h0002, 0, 0, lat);
        check("div_res", 32'(resultAccumulator), 32'hFFFD);
        run_op(OP_MOD, 16'hFFF9, 16'h0002, 0, 0, lat);
        check("mod_res", 32'(resultAccumulator), 32'hFFFF);

        run_op(OP_DIV, 16'h0005, 16'h0000, 0, 0, lat);
        check("div0_res", 32'(resultAccumulator), 32'hFFFF);
        check("div0_flags", 32'(flags), 32'b1001);
        check("div0_lat", lat, 1);

        run_op(OP_DIV, 16'h8000, 16'hFFFF, 0, 0, lat);
        check("divmin_res", 32'(resultAccumulator), 32'h8000);
        check("divmin_flags", 32'(flags), 32'b1001);
        check("divmin_lat", lat, 18);

        run_op(OP_CLR, 16'h1234, 16'h5678, 0, 0, lat);
        check("clr_res", 32'(resultAccumulator), 0);
        run_op(OP_MAC, 16'h0003, 16'h0004, 0, 0, lat);
        check("mac1_res", 32'(resultAccumulator), 32'd12);
        run_op(OP_MAC, 16'hFFFE, 16'h0005, 0, 0, lat);
        check("mac2_res", 32'(resultAccumulator), 32'd2);
        check("mac2_flags", 32'(flags), 32'b0000);

        run_op(OP_MUL, 16'h0123, 16'h0045, 5, 1, lat);
        check("rst_abort_nodone", lat, 40);
        check("rst_abort_res", 32'(resultAccumulator), 0);
        check("rst_abort_busy", 32'(busy), 0);
        run_op(OP_ADD, 16'h0002, 16'h0003, 0, 0, lat);
        check("post_rst_add", 32'(resultAccumulator), 32'h0005);
        check("post_rst_lat", lat, 1);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            start    = ($urandom_range(0, 2) == 0);
            alu_op   = 5'($urandom_range(0, 19));
            operandA = rand_val();
            operandB = rand_val();
            rst      = ($urandom_range(0, 799) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        repeat (W + 4) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
